sdram_init_checker: RTL and testbench

Passive responder-side monitor for the SDRAM power-up sequence. Sits on the controller-to-device command bus, alongside the SDRAM model in simulation or on the pins in FPGA debug builds. It samples {CS#, RAS#, CAS#, WE#}, bank and address every cycle and checks the JEDEC order: power-up wait, PRECHARGE-ALL, CNT_AR AUTO REFRESH, MODE REGISTER SET. It enforces tRP/tRFC/tMRD spacing, decodes the programmed mode register and reports done or a sticky first-error code.

---
 rtl/sdram_init_checker_pkg.sv | 75 +++++++
 rtl/sdram_cmd_decode.sv | 45 ++++
 rtl/sdram_init_checker.sv | 216 +++++++++++++++++++++
 tb/tb_sdram_init_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_init_checker_pkg.sv
// sdram_init_checker_pkg
//
// Shared definitions for the SDRAM command-bus monitors: command encodings
// on {CS#, RAS#, CAS#, WE#}, error codes reported by the init checker,
// checker state codes and the mode-register decode helper.
//
// No ports (package).

package sdram_init_checker_pkg;

    // Command encodings {CS#, RAS#, CAS#, WE#} with CS# asserted (low).
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    // Gap counter: cycles since the last non-NOP command, saturating.
    localparam int         GAP_W   = 8;
    localparam logic [7:0] GAP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_EARLY = 3'd1,
        ERR_SEQ   = 3'd2,
        ERR_TRP   = 3'd3,
        ERR_TRFC  = 3'd4,
        ERR_TMRD  = 3'd5,
        ERR_MODE  = 3'd6,
        ERR_END   = 3'd7
    } err_code_e;

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_PRE  = 3'd1,
        S_AR   = 3'd2,
        S_MRS  = 3'd3,
        S_TMRD = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } chk_state_e;

    typedef struct packed {
        logic [2:0] cl;
        logic [2:0] bl;
        logic       il;
        logic       swb;
    } mode_fields_t;

    typedef struct packed {
        logic         legal;
        mode_fields_t fields;
    } mode_dec_t;

    // Decode an MRS bank/address pair. Only CL 2/3 and BL 1/2/4/8/full page
    // are accepted; reserved bits and the bank address must be zero.
    function automatic mode_dec_t mode_decode(input logic [1:0]  bank,
                                              input logic [12:0] addr);
        mode_dec_t r;
        r.fields.cl  = addr[6:4];
        r.fields.bl  = addr[2:0];
        r.fields.il  = addr[3];
        r.fields.swb = addr[9];
        r.legal = (bank == 2'b00) &&
                  (addr[12:10] == 3'b000) &&
                  (addr[8:7] == 2'b00) &&
                  (addr[6:4] inside {3'b010, 3'b011}) &&
                  (addr[2:0] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b111});
        return r;
    endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// sdram_cmd_decode
//
// Combinational one-hot classification of an SDRAM command code. A
// deselected bus (CS# high) is reported as NOP. ACT/RD/WR/BST and any
// unlisted code are grouped as "other".
//
// Ports:
//   mon_cmd   in  4  {CS#, RAS#, CAS#, WE#}
//   is_nop    out 1  NOP or deselect
//   is_pre    out 1  PRECHARGE
//   is_ar     out 1  AUTO REFRESH
//   is_mrs    out 1  MODE REGISTER SET
//   is_other  out 1  any other command

module sdram_cmd_decode
    import sdram_init_checker_pkg::*;
(
    input  logic [3:0] mon_cmd,
    output logic       is_nop,
    output logic       is_pre,
    output logic       is_ar,
    output logic       is_mrs,
    output logic       is_other
);

    always_comb begin
        is_nop   = 1'b0;
        is_pre   = 1'b0;
        is_ar    = 1'b0;
        is_mrs   = 1'b0;
        is_other = 1'b0;
        if (mon_cmd[3]) begin
            is_nop = 1'b1;
        end else begin
            case (mon_cmd)
                CMD_NOP: is_nop   = 1'b1;
                CMD_PRE: is_pre   = 1'b1;
                CMD_AR:  is_ar    = 1'b1;
                CMD_MRS: is_mrs   = 1'b1;
                default: is_other = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/sdram_init_checker.sv
// sdram_init_checker
//
// Passive monitor of the SDRAM power-up command sequence: power-up wait,
// PRECHARGE-ALL, CNT_AR AUTO REFRESH, MODE REGISTER SET. Checks ordering and
// tRP/tRFC/tMRD spacing, decodes the programmed mode register, and reports
// either a sticky done flag or a sticky first-error code.
//
// Ports:
//   init_clk      in  1   clock
//   init_rst_n    in  1   asynchronous active-low reset
//   mon_cmd       in  4   {CS#, RAS#, CAS#, WE#}
//   mon_bank      in  2   bank address
//   mon_addr      in  13  address bus
//   mon_init_end  in  1   controller's init-done flag
//   chk_done      out 1   sequence completed legally (sticky)
//   chk_err       out 1   violation detected (sticky)
//   err_code      out 3   first error code
//   ar_seen       out 4   accepted AUTO REFRESH count, saturating at 15
//   mode_cl       out 3   CAS latency (A6:A4)
//   mode_bl       out 3   burst length (A2:A0)
//   mode_il       out 1   interleaved burst (A3)
//   mode_swb      out 1   single-write burst (A9)

module sdram_init_checker
    import sdram_init_checker_pkg::*;
#(
    parameter int CNT_WAIT = 10000,
    parameter int TRP      = 3,
    parameter int TRFC     = 7,
    parameter int TMRD     = 2,
    parameter int CNT_AR   = 2
) (
    input  logic        init_clk,
    input  logic        init_rst_n,
    input  logic [3:0]  mon_cmd,
    input  logic [1:0]  mon_bank,
    input  logic [12:0] mon_addr,
    input  logic        mon_init_end,
    output logic        chk_done,
    output logic        chk_err,
    output logic [2:0]  err_code,
    output logic [3:0]  ar_seen,
    output logic [2:0]  mode_cl,
    output logic [2:0]  mode_bl,
    output logic        mode_il,
    output logic        mode_swb
);

    localparam int               PWR_W    = (CNT_WAIT < 1) ? 1 : $clog2(CNT_WAIT + 1);
    localparam logic [PWR_W-1:0] PWR_MAX  = PWR_W'(CNT_WAIT);
    localparam logic [GAP_W-1:0] TRP_G    = GAP_W'(TRP);
    localparam logic [GAP_W-1:0] TRFC_G   = GAP_W'(TRFC);
    localparam logic [GAP_W-1:0] TMRD_G   = GAP_W'(TMRD);
    localparam logic [4:0]       AR_REQ   = 5'(CNT_AR);

    logic is_nop, is_pre, is_ar, is_mrs, is_other;
    logic cmd_act;

    sdram_cmd_decode u_decode (
        .mon_cmd  (mon_cmd),
        .is_nop   (is_nop),
        .is_pre   (is_pre),
        .is_ar    (is_ar),
        .is_mrs   (is_mrs),
        .is_other (is_other)
    );

    assign cmd_act = is_pre | is_ar | is_mrs | is_other;

    chk_state_e       state_q,    state_d;
    logic [PWR_W-1:0] pwr_cnt_q,  pwr_cnt_d;
    logic [GAP_W-1:0] gap_q,      gap_d;
    logic [3:0]       ar_seen_q,  ar_seen_d;
    logic             chk_done_q, chk_done_d;
    logic             chk_err_q,  chk_err_d;
    err_code_e        err_code_q, err_code_d;
    mode_fields_t     mode_q,     mode_d;

    mode_dec_t        mode_dec;
    logic             f_early, f_seq, f_mode, f_end;
    err_code_e        time_code;

    assign mode_dec = mode_decode(mon_bank, mon_addr);

    always_comb begin
        state_d    = state_q;
        ar_seen_d  = ar_seen_q;
        chk_done_d = chk_done_q;
        chk_err_d  = chk_err_q;
        err_code_d = err_code_q;
        mode_d     = mode_q;
        f_early    = 1'b0;
        f_seq      = 1'b0;
        f_mode     = 1'b0;
        f_end      = 1'b0;
        time_code  = ERR_NONE;

        pwr_cnt_d = (pwr_cnt_q >= PWR_MAX) ? PWR_MAX : pwr_cnt_q + PWR_W'(1);

        // gap_q holds (current cycle - cycle of last non-NOP command).
        if (is_nop) begin
            gap_d = (gap_q == GAP_MAX) ? GAP_MAX : gap_q + GAP_W'(1);
        end else begin
            gap_d = GAP_W'(1);
        end

        case (state_q)
            // S_WAIT and S_PRE differ only in whether the power-up wait has
            // elapsed; pwr_cnt_q decides legality so both share one check.
            S_WAIT, S_PRE: begin
                state_d = (pwr_cnt_d >= PWR_MAX) ? S_PRE : S_WAIT;
                if (cmd_act) begin
                    if (pwr_cnt_q < PWR_MAX) begin
                        f_early = 1'b1;
                    end else if (is_pre && mon_addr[10]) begin
                        state_d = S_AR;
                    end else begin
                        f_seq = 1'b1;
                    end
                end
            end

            S_AR: begin
                if (cmd_act) begin
                    if (is_ar) begin
                        if (ar_seen_q == 4'd0) begin
                            if (gap_q < TRP_G) time_code = ERR_TRP;
                        end else begin
                            if (gap_q < TRFC_G) time_code = ERR_TRFC;
                        end
                        ar_seen_d = (ar_seen_q == 4'hF) ? ar_seen_q : ar_seen_q + 4'd1;
                        if (({1'b0, ar_seen_q} + 5'd1) >= AR_REQ) state_d = S_MRS;
                    end else begin
                        f_seq = 1'b1;
                    end
                end
            end

            S_MRS: begin
                if (cmd_act) begin
                    if (is_mrs) begin
                        if (gap_q < TRFC_G) time_code = ERR_TRFC;
                        if (!mode_dec.legal) f_mode = 1'b1;
                        mode_d  = mode_dec.fields;
                        state_d = S_TMRD;
                    end else begin
                        // Includes an AR beyond the required count.
                        f_seq = 1'b1;
                    end
                end
            end

            S_TMRD: begin
                if (cmd_act && (gap_q < TMRD_G)) begin
                    time_code = ERR_TMRD;
                end else if (gap_q >= TMRD_G) begin
                    state_d    = S_DONE;
                    chk_done_d = 1'b1;
                end
            end

            default: ;
        endcase

        if (mon_init_end && (state_q != S_DONE) && (state_q != S_ERR)) begin
            f_end = 1'b1;
        end

        // Any violation discards this cycle's progress and records only the
        // highest-priority code.
        if (f_early || f_seq || (time_code != ERR_NONE) || f_mode || f_end) begin
            state_d    = S_ERR;
            chk_err_d  = 1'b1;
            chk_done_d = chk_done_q;
            ar_seen_d  = ar_seen_q;
            mode_d     = mode_q;
            if (f_early)                    err_code_d = ERR_EARLY;
            else if (f_seq)                 err_code_d = ERR_SEQ;
            else if (time_code != ERR_NONE) err_code_d = time_code;
            else if (f_mode)                err_code_d = ERR_MODE;
            else                            err_code_d = ERR_END;
        end
    end

    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            state_q    <= S_WAIT;
            pwr_cnt_q  <= '0;
            gap_q      <= GAP_MAX;
            ar_seen_q  <= '0;
            chk_done_q <= 1'b0;
            chk_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            mode_q     <= '0;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            gap_q      <= gap_d;
            ar_seen_q  <= ar_seen_d;
            chk_done_q <= chk_done_d;
            chk_err_q  <= chk_err_d;
            err_code_q <= err_code_d;
            mode_q     <= mode_d;
        end
    end

    assign chk_done = chk_done_q;
    assign chk_err  = chk_err_q;
    assign err_code = err_code_q;
    assign ar_seen  = ar_seen_q;
    assign mode_cl  = mode_q.cl;
    assign mode_bl  = mode_q.bl;
    assign mode_il  = mode_q.il;
    assign mode_swb = mode_q.swb;

endmodule

// File: tb/tb_sdram_init_checker.sv
// tb_sdram_init_checker
//
// Directed bench for sdram_init_checker with CNT_WAIT=20, TRP=3, TRFC=7,
// TMRD=2, CNT_AR=2. Cycle numbers count posedges after reset release, the
// first one being cycle 0.

module tb_sdram_init_checker;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] AR  = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;
    localparam logic [3:0] ACT = 4'b0011;

    logic        init_clk;
    logic        init_rst_n;
    logic [3:0]  mon_cmd;
    logic [1:0]  mon_bank;
    logic [12:0] mon_addr;
    logic        mon_init_end;
    logic        chk_done;
    logic        chk_err;
    logic [2:0]  err_code;
    logic [3:0]  ar_seen;
    logic [2:0]  mode_cl;
    logic [2:0]  mode_bl;
    logic        mode_il;
    logic        mode_swb;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sdram_init_checker #(
        .CNT_WAIT (20),
        .TRP      (3),
        .TRFC     (7),
        .TMRD     (2),
        .CNT_AR   (2)
    ) dut (
        .init_clk     (init_clk),
        .init_rst_n   (init_rst_n),
        .mon_cmd      (mon_cmd),
        .mon_bank     (mon_bank),
        .mon_addr     (mon_addr),
        .mon_init_end (mon_init_end),
        .chk_done     (chk_done),
        .chk_err      (chk_err),
        .err_code     (err_code),
        .ar_seen      (ar_seen),
        .mode_cl      (mode_cl),
        .mode_bl      (mode_bl),
        .mode_il      (mode_il),
        .mode_swb     (mode_swb)
    );

    initial begin
        init_clk = 1'b0;
        forever #5 init_clk = ~init_clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one command for the current cycle, let the edge sample it, then
    // return the bus to NOP. Outputs are read 1 time unit after the edge.
    task automatic step(input logic [3:0] cmd, input logic [1:0] bank,
                        input logic [12:0] addr, input logic ie);
        mon_cmd      = cmd;
        mon_bank     = bank;
        mon_addr     = addr;
        mon_init_end = ie;
        @(posedge init_clk);
        #1;
        cyc++;
        mon_cmd      = NOP;
        mon_bank     = 2'b00;
        mon_addr     = 13'h0;
        mon_init_end = 1'b0;
    endtask

    task automatic cmd_at(input int c, input logic [3:0] cmd, input logic [1:0] bank,
                          input logic [12:0] addr, input logic ie);
        while (cyc < c) step(NOP, 2'b00, 13'h0, 1'b0);
        step(cmd, bank, addr, ie);
    endtask

    task automatic nop_to(input int c);
        while (cyc < c) step(NOP, 2'b00, 13'h0, 1'b0);
    endtask

    task automatic reset_assert();
        init_rst_n   = 1'b0;
        mon_cmd      = NOP;
        mon_bank     = 2'b00;
        mon_addr     = 13'h0;
        mon_init_end = 1'b0;
        #2;
    endtask

    task automatic reset_release();
        repeat (2) @(posedge init_clk);
        @(negedge init_clk);
        init_rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic apply_reset();
        reset_assert();
        reset_release();
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_done"},  {15'd0, chk_done}, 16'd0);
        check({pfx, "_err"},   {15'd0, chk_err},  16'd0);
        check({pfx, "_code"},  {13'd0, err_code}, 16'd0);
        check({pfx, "_ar"},    {12'd0, ar_seen},  16'd0);
        check({pfx, "_cl"},    {13'd0, mode_cl},  16'd0);
        check({pfx, "_bl"},    {13'd0, mode_bl},  16'd0);
        check({pfx, "_il"},    {15'd0, mode_il},  16'd0);
        check({pfx, "_swb"},   {15'd0, mode_swb}, 16'd0);
    endtask

    task automatic legal_front();
        cmd_at(21, PRE, 2'b00, 13'h400, 1'b0);
        cmd_at(24, AR,  2'b00, 13'h000, 1'b0);
        cmd_at(31, AR,  2'b00, 13'h000, 1'b0);
    endtask

    initial begin
        init_rst_n   = 1'b0;
        mon_cmd      = NOP;
        mon_bank     = 2'b00;
        mon_addr     = 13'h0;
        mon_init_end = 1'b0;

        // Legal sequence, MRS 0x037 -> CL3, BL7
        apply_reset();
        check_idle("rst");
        cmd_at(21, PRE, 2'b00, 13'h400, 1'b0);
        check("leg_pre_err", {15'd0, chk_err}, 16'd0);
        cmd_at(24, AR, 2'b00, 13'h000, 1'b0);
        check("leg_ar1", {12'd0, ar_seen}, 16'd1);
        cmd_at(31, AR, 2'b00, 13'h000, 1'b0);
        check("leg_ar2", {12'd0, ar_seen}, 16'd2);
        cmd_at(38, MRS, 2'b00, 13'h037, 1'b0);
        check("leg_cl_latch", {13'd0, mode_cl}, 16'd3);
        step(NOP, 2'b00, 13'h0, 1'b0);
        check("leg_done_39", {15'd0, chk_done}, 16'd0);
        step(NOP, 2'b00, 13'h0, 1'b0);
        check("leg_done_40", {15'd0, chk_done}, 16'd1);
        cmd_at(41, NOP, 2'b00, 13'h0, 1'b1);
        step(ACT, 2'b01, 13'h1FFF, 1'b0);
        check("leg_done", {15'd0, chk_done}, 16'd1);
        check("leg_err",  {15'd0, chk_err},  16'd0);
        check("leg_code", {13'd0, err_code}, 16'd0);
        check("leg_cl",   {13'd0, mode_cl},  16'd3);
        check("leg_bl",   {13'd0, mode_bl},  16'd7);
        check("leg_il",   {15'd0, mode_il},  16'd0);
        check("leg_swb",  {15'd0, mode_swb}, 16'd0);

        // EARLY: PRE at cycle 15, later legal sequence must not complete
        apply_reset();
        cmd_at(15, PRE, 2'b00, 13'h400, 1'b0);
        check("early_err",  {15'd0, chk_err},  16'd1);
        check("early_code", {13'd0, err_code}, 16'd1);
        legal_front();
        cmd_at(38, MRS, 2'b00, 13'h037, 1'b0);
        nop_to(45);
        check("early_done", {15'd0, chk_done}, 16'd0);
        check("early_code_hold", {13'd0, err_code}, 16'd1);

        // PRE without A10 -> SEQ
        apply_reset();
        cmd_at(21, PRE, 2'b00, 13'h000, 1'b0);
        check("pre_a10_code", {13'd0, err_code}, 16'd2);

        // AR 2 cycles after PRE -> TRP
        apply_reset();
        cmd_at(21, PRE, 2'b00, 13'h400, 1'b0);
        cmd_at(23, AR,  2'b00, 13'h000, 1'b0);
        check("trp_code", {13'd0, err_code}, 16'd3);
        check("trp_ar",   {12'd0, ar_seen},  16'd0);

        // Second AR 5 cycles after the first -> TRFC
        apply_reset();
        cmd_at(21, PRE, 2'b00, 13'h400, 1'b0);
        cmd_at(24, AR,  2'b00, 13'h000, 1'b0);
        cmd_at(29, AR,  2'b00, 13'h000, 1'b0);
        check("trfc_code", {13'd0, err_code}, 16'd4);
        check("trfc_ar",   {12'd0, ar_seen},  16'd1);

        // MRS after only one AR -> SEQ
        apply_reset();
        cmd_at(21, PRE, 2'b00, 13'h400, 1'b0);
        cmd_at(24, AR,  2'b00, 13'h000, 1'b0);
        cmd_at(31, MRS, 2'b00, 13'h037, 1'b0);
        check("mrs1ar_code", {13'd0, err_code}, 16'd2);

        // Third AR -> SEQ
        apply_reset();
        legal_front();
        cmd_at(38, AR, 2'b00, 13'h000, 1'b0);
        check("ar3_code", {13'd0, err_code}, 16'd2);
        check("ar3_ar",   {12'd0, ar_seen},  16'd2);

        // MRS with CL5 -> MODE, mode outputs stay 0
        apply_reset();
        legal_front();
        cmd_at(38, MRS, 2'b00, 13'h057, 1'b0);
        check("cl5_code", {13'd0, err_code}, 16'd6);
        check("cl5_cl",   {13'd0, mode_cl},  16'd0);
        check("cl5_bl",   {13'd0, mode_bl},  16'd0);

        // MRS on bank 01 -> MODE
        apply_reset();
        legal_front();
        cmd_at(38, MRS, 2'b01, 13'h037, 1'b0);
        check("bank_code", {13'd0, err_code}, 16'd6);
        check("bank_bl",   {13'd0, mode_bl},  16'd0);

        // ACT one cycle after MRS -> TMRD
        apply_reset();
        legal_front();
        cmd_at(38, MRS, 2'b00, 13'h037, 1'b0);
        cmd_at(39, ACT, 2'b00, 13'h000, 1'b0);
        check("tmrd_code", {13'd0, err_code}, 16'd5);
        nop_to(45);
        check("tmrd_done", {15'd0, chk_done}, 16'd0);
        check("tmrd_err",  {15'd0, chk_err},  16'd1);

        // init_end pulsed during S_AR -> END
        apply_reset();
        cmd_at(21, PRE, 2'b00, 13'h400, 1'b0);
        cmd_at(24, AR,  2'b00, 13'h000, 1'b0);
        cmd_at(26, NOP, 2'b00, 13'h000, 1'b1);
        check("end_code", {13'd0, err_code}, 16'd7);

        // Simultaneous EARLY and END -> EARLY wins
        apply_reset();
        cmd_at(10, PRE, 2'b00, 13'h400, 1'b1);
        check("prio_code", {13'd0, err_code}, 16'd1);

        // Reset mid-sequence, then a full legal sequence with MRS 0x22A
        apply_reset();
        cmd_at(21, PRE, 2'b00, 13'h400, 1'b0);
        cmd_at(24, AR,  2'b00, 13'h000, 1'b0);
        nop_to(30);
        check("mid_ar_before", {12'd0, ar_seen}, 16'd1);
        reset_assert();
        check_idle("mid_rst");
        reset_release();
        cmd_at(19, PRE, 2'b00, 13'h400, 1'b0);
        check("mid_restart_early", {13'd0, err_code}, 16'd1);
        apply_reset();
        legal_front();
        cmd_at(38, MRS, 2'b00, 13'h22A, 1'b0);
        nop_to(41);
        check("mid_done", {15'd0, chk_done}, 16'd1);
        check("mid_err",  {15'd0, chk_err},  16'd0);
        check("mid_cl",   {13'd0, mode_cl},  16'd2);
        check("mid_bl",   {13'd0, mode_bl},  16'd2);
        check("mid_il",   {15'd0, mode_il},  16'd1);
        check("mid_swb",  {15'd0, mode_swb}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
